iter_div: RTL and testbench
===========================

# iter_div

Multi-cycle iterative 32-bit divider for the EX stage of the 5-stage MIPS pipeline. It accepts DIV/DIVU operands from EX, computes the quotient and remainder with a radix-2 restoring algorithm, and drives `div_stop` into the hazard unit so that EX is stalled while the division is in flight. It releases `div_stop` in the single cycle in which results are valid, and EX writes HI/LO from those results.

## Interface
- No parameters; the datapath width is fixed at 32.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `div_start` input 1: the EX instruction is valid and is DIV/DIVU. Held high by EX for as long as the instruction remains in EX.
- `div_signed` input 1: 1 selects DIV, 0 selects DIVU. Sampled with `div_start` in IDLE.
- `div_src1` input 32: dividend. Sampled in IDLE.
- `div_src2` input 32: divisor. Sampled in IDLE.
- `es_flush` input 1: exception/ERET flush. Cancels any division in progress.
- `div_stop` output 1: stall request to the hazard unit (EX stall).
- `div_done` output 1: one-cycle pulse; results are valid in this cycle.
- `div_quotient` output 32: quotient, written to LO.
- `div_remainder` output 32: remainder, written to HI.

## Operation
- FSM states: IDLE, BUSY, DONE. Iteration counter `cnt` is 6 bits.
- IDLE:
  - If `div_start && !es_flush`, latch |src1|, |src2|, sign flags and `div_signed`, clear the partial remainder, set `cnt=0`, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: each cycle performs one restoring step:
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem − divisor (33-bit).
  - If trial is non-negative, rem = trial and the new quotient bit is 1; otherwise the quotient bit is 0.
  - `cnt++`. After the step with `cnt==31`, go to DONE.
- DONE: register `div_quotient`/`div_remainder` with sign fixup applied, assert `div_done`, and return to IDLE.
- Sign fixup, applied only when `div_signed=1`:
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Absolute values use 32-bit two's complement. 0x80000000 is therefore treated as an unsigned magnitude of 2^31, and 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0 with no trap.
- Divide by zero follows from the algorithm with no special handling:
  - q=0xFFFFFFFF before fixup.
  - r=|src1| before fixup.
  - After fixup: q=1 if `div_signed` and src1 is negative, else q=0xFFFFFFFF; r=src1.
- `div_stop = !es_flush && ((state==IDLE && div_start) || state==BUSY)`. It is low in DONE.
- `es_flush` in any state forces IDLE on the next edge. The result registers are not updated and `div_done` is not pulsed.
- `div_quotient`/`div_remainder` hold their values until the next DONE.

## Timing
- Reset values: state=IDLE, `cnt=0`, `div_stop=0` (given `div_start=0`), `div_done=0`, `div_quotient=0`, `div_remainder=0`.
- Assertion of `resetn` mid-operation aborts immediately and asynchronously; no result is produced.
- Start in cycle T (IDLE with `div_start=1`):
  - BUSY occupies T+1 through T+32.
  - DONE occurs in T+33, with `div_done=1` and results valid.
  - `div_stop` is high for T..T+32 (33 cycles) and low in T+33.
- Results are registered on the edge entering DONE, so they are stable throughout the DONE cycle.
- Back-to-back divides:
  - The EX instruction advances at the end of DONE, and the FSM is back in IDLE in T+34.
  - If a new DIV is in EX at T+34, it starts there. No start is accepted in the DONE cycle itself.
- The hazard unit prioritises `div_stop` below the branch-use stall. The branch-use stall never freezes EX, so it cannot interfere with DONE.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - In IDLE, if `div_start` and `div_src2==0`, go directly to DONE with the divide-by-zero result values defined above.
  - `div_stop` is high only in T, and `div_done` pulses in T+1.
- `DIV_ZERO_FAST_EN` undefined: divide by zero takes the full 33-cycle latency.
- Result values are identical with and without the macro; only latency differs.

## Test plan
- DIVU 100 / 7, start at T:
  - `div_stop` is high for exactly 33 cycles.
  - `div_done` pulses at T+33 with q=14 (0x0000000E), r=2.
- DIV 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (−2) → q=0xFFFFFFFD, r=1.
- DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, with no stall beyond the 33 cycles.
- DIVU 5 / 0 → q=0xFFFFFFFF, r=5. DIV 0xFFFFFFFB / 0 → q=1, r=0xFFFFFFFB.
  - With `DIV_ZERO_FAST_EN`: `div_done` at T+1 and `div_stop` high for 1 cycle.
  - Without it: `div_done` at T+33.
- `es_flush` at BUSY cycle T+10:
  - At T+11 the FSM is in IDLE, `div_stop=0`, and `div_done` never pulses.
  - Outputs keep the prior result.
  - A following DIVU 9 / 3 gives q=3, r=0 at its start+33.
- `resetn` pulsed low at T+5: all outputs read 0 immediately. Two back-to-back DIVUs (20/6, then 21/4) complete at T+33 and T+67 with (3,2) and (5,1).

Source files
------------

// File: rtl/iter_div.sv
// iter_div: 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Ports: clk, resetn (async, active-low); div_start, div_signed,
//   div_src1 (dividend), div_src2 (divisor), es_flush (cancel) in;
//   div_stop (EX stall), div_done (result pulse), div_quotient (LO),
//   div_remainder (HI) out.
// Optional macro DIV_ZERO_FAST_EN: divide by zero completes in one cycle.
module iter_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        es_flush,
    output logic        div_stop,
    output logic        div_done,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef DIV_ZERO_FAST_EN
    localparam bit ZERO_FAST = 1'b1;
`else
    localparam bit ZERO_FAST = 1'b0;
`endif

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] shl;
    logic [32:0] trial;
    logic        qbit;
    logic [31:0] rem_nxt;
    logic [31:0] dvd_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // 0x80000000 negates to itself, giving an unsigned magnitude of 2^31.
    assign abs1 = (div_signed && div_src1[31]) ? -div_src1 : div_src1;
    assign abs2 = (div_signed && div_src2[31]) ? -div_src2 : div_src2;

    // The dividend register doubles as the quotient: quotient bits are
    // shifted in at the bottom as dividend bits leave at the top.
    // rem < divisor, so a 33-bit trial subtraction never overflows.
    assign shl     = {rem, dvd[31]};
    assign trial   = shl - {1'b0, dvs};
    assign qbit    = ~trial[32];
    assign rem_nxt = qbit ? trial[31:0] : shl[31:0];
    assign dvd_nxt = {dvd[30:0], qbit};

    assign q_fix = neg_q ? -dvd_nxt : dvd_nxt;
    assign r_fix = neg_r ? -rem_nxt : rem_nxt;

    assign div_stop = !es_flush &&
                      ((state == IDLE && div_start) || state == BUSY);
    assign div_done = (state == DONE) && !es_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (es_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (div_start) begin
                        if (ZERO_FAST && div_src2 == '0) begin
                            // Same values the full algorithm would yield.
                            state         <= DONE;
                            div_quotient  <= (div_signed && div_src1[31]) ?
                                             32'd1 : 32'hFFFF_FFFF;
                            div_remainder <= div_src1;
                        end else begin
                            state <= BUSY;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= abs1;
                            dvs   <= abs2;
                            neg_q <= div_signed &&
                                     (div_src1[31] ^ div_src2[31]);
                            neg_r <= div_signed && div_src1[31];
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state         <= DONE;
                        div_quotient  <= q_fix;
                        div_remainder <= r_fix;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed self-checking bench for iter_div with an
// arithmetic reference model and a per-cycle compare process.
module tb_iter_div;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        es_flush;
    logic        div_stop;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    iter_div dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .es_flush      (es_flush),
        .div_stop      (div_stop),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    // Model state: stall window, expected done cycle, visible results.
    int          exp_lo   = 0;
    int          exp_hi   = -1;
    int          exp_done = -1;
    logic [31:0] nxt_q    = '0;
    logic [31:0] nxt_r    = '0;
    logic [31:0] cur_q    = '0;
    logic [31:0] cur_r    = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    task automatic ref_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endtask

    function automatic int latency(input logic [31:0] b);
        int l;
        l = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) l = 1;
`endif
        return l;
    endfunction

    // Compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        logic e_stop;
        if (!resetn) begin
            cur_q = '0;
            cur_r = '0;
            chk("rst_stop", {31'd0, div_stop}, 32'd0);
            chk("rst_done", {31'd0, div_done}, 32'd0);
            chk("rst_q", div_quotient, 32'd0);
            chk("rst_r", div_remainder, 32'd0);
        end else begin
            if (cyc == exp_done) begin
                cur_q = nxt_q;
                cur_r = nxt_r;
            end
            e_stop = !es_flush && cyc >= exp_lo && cyc <= exp_hi;
            chk("stop", {31'd0, div_stop}, {31'd0, e_stop});
            chk("done", {31'd0, div_done}, {31'd0, cyc == exp_done});
            chk("q", div_quotient, cur_q);
            chk("r", div_remainder, cur_r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the FSM idle; returns start cycle.
    task automatic begin_op(input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, output int t);
        logic [31:0] q;
        logic [31:0] r;
        int          l;
        ref_div(sgn, a, b, q, r);
        l        = latency(b);
        t        = cyc;
        nxt_q    = q;
        nxt_r    = r;
        exp_lo   = t;
        exp_hi   = t + l - 1;
        exp_done = t + l;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        div_start  = 1'b1;
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er);
        int t;
        int stops;
        int l;
        begin_op(sgn, a, b, t);
        l = latency(b);
        stops = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stop) stops++;
            if (div_done) break;
            step();
        end
        chk("lit_done", {31'd0, div_done}, 32'd1);
        chk("lit_done_cyc", cyc, t + l);
        chk("lit_stop_len", stops, l);
        chk("lit_q", div_quotient, eq);
        chk("lit_r", div_remainder, er);
        step();
        div_start = 1'b0;
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        int          t;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        es_flush   = 1'b0;

        // Pin the reference model with hand-computed values.
        ref_div(1'b0, 32'd100, 32'd7, mq, mr);
        chk("model_100_7_q", mq, 32'd14);
        chk("model_100_7_r", mr, 32'd2);
        ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr);
        chk("model_m7_2_q", mq, 32'hFFFF_FFFD);
        chk("model_m7_2_r", mr, 32'hFFFF_FFFF);
        ref_div(1'b1, 32'hFFFF_FFFB, 32'd0, mq, mr);
        chk("model_dz_q", mq, 32'd1);
        chk("model_dz_r", mr, 32'hFFFF_FFFB);

        repeat (3) step();
        resetn = 1'b1;
        step();
        step();

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        step();
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
        step();

        // Flush during BUSY at T+10.
        begin_op(1'b0, 32'd1000, 32'd3, t);
        repeat (10) step();
        es_flush = 1'b1;
        exp_done = -1;
        exp_hi   = cyc;
        step();
        es_flush  = 1'b0;
        div_start = 1'b0;
        @(negedge clk);
        chk("flush_stop", {31'd0, div_stop}, 32'd0);
        chk("flush_keep_q", div_quotient, 32'd1);
        chk("flush_keep_r", div_remainder, 32'hFFFF_FFFB);
        repeat (40) step();
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Asynchronous reset at T+5.
        begin_op(1'b0, 32'd77, 32'd5, t);
        repeat (5) step();
        resetn    = 1'b0;
        div_start = 1'b0;
        exp_lo    = 0;
        exp_hi    = -1;
        exp_done  = -1;
        #1;
        chk("arst_stop", {31'd0, div_stop}, 32'd0);
        chk("arst_done", {31'd0, div_done}, 32'd0);
        chk("arst_q", div_quotient, 32'd0);
        chk("arst_r", div_remainder, 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Back-to-back: second starts in the cycle after DONE.
        run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2);
        run_div(1'b0, 32'd21, 32'd4, 32'd5, 32'd1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
